// File: rtl/axis_frame_sync.sv
// axis_frame_sync: AXI4-Stream frame conformance stage.
// Emits exactly H_RES x V_RES beats per frame, padding or dropping.
module axis_frame_sync #(
  parameter int H_RES = 800,
  parameter int V_RES = 600,
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_PIXEL = 16'h0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  clr_err_i,
  output logic                  locked_o,
  output logic                  sof_err_o,
  output logic                  line_err_o,
  output logic [15:0]           err_cnt_o
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  localparam logic [2:0] SEEK      = 3'd0;
  localparam logic [2:0] PASS      = 3'd1;
  localparam logic [2:0] PAD_LINE  = 3'd2;
  localparam logic [2:0] DROP_LINE = 3'd3;
  localparam logic [2:0] PAD_FRAME = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_n;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_last;

  logic                  out_free;
  logic                  rdy;
  logic                  acc;
  logic                  in_sof;
  logic                  at_sof;
  logic                  at_eol;
  logic                  emit;
  logic                  cap;
  logic                  sof_e;
  logic                  line_e;
  logic [DATA_WIDTH-1:0] emit_data;
  logic [USER_WIDTH-1:0] user_v;
  logic [16:0]           cnt_sum;

  assign out_free = ~m_axis_tvalid | m_axis_tready;
  assign at_sof   = (x == '0) && (y == '0);
  assign at_eol   = (x == X_LAST);
  assign in_sof   = s_axis_tuser[0];

  always_comb begin
    rdy = 1'b0;
    unique case (state)
      SEEK:      rdy = out_free;
      PASS:      rdy = out_free;
      DROP_LINE: rdy = 1'b1;
      default:   rdy = 1'b0;
    endcase
  end

  assign s_axis_tready = ~rst_i & rdy;
  assign acc = s_axis_tvalid & s_axis_tready;
  assign locked_o = (state != SEEK);

  // Frame/line markers come from the counters, never from the input.
  always_comb begin
    user_v    = '0;
    user_v[0] = at_sof;
  end

  always_comb begin
    state_n   = state;
    emit      = 1'b0;
    emit_data = FILL_PIXEL;
    cap       = 1'b0;
    sof_e     = 1'b0;
    line_e    = 1'b0;
    unique case (state)
      SEEK: begin
        if (acc && in_sof) begin
          emit      = 1'b1;
          emit_data = s_axis_tdata;
          if (s_axis_tlast) begin
            line_e  = 1'b1;
            state_n = PAD_LINE;
          end else begin
            state_n = PASS;
          end
        end
      end
      PASS: begin
        if (acc) begin
          if (in_sof && !at_sof) begin
            cap     = 1'b1;
            sof_e   = 1'b1;
            state_n = PAD_FRAME;
          end else if (at_sof && !in_sof) begin
            sof_e   = 1'b1;
            state_n = SEEK;
          end else begin
            emit      = 1'b1;
            emit_data = s_axis_tdata;
            if (at_eol) begin
              if (!s_axis_tlast) begin
                line_e  = 1'b1;
                state_n = DROP_LINE;
              end
            end else if (s_axis_tlast) begin
              line_e  = 1'b1;
              state_n = PAD_LINE;
            end
          end
        end
      end
      PAD_LINE: begin
        if (out_free) begin
          emit = 1'b1;
          if (at_eol) state_n = PASS;
        end
      end
      DROP_LINE: begin
        if (acc) begin
          if (in_sof) begin
            // A SOF landing exactly on (0,0) is well placed.
            cap     = 1'b1;
            sof_e   = ~at_sof;
            state_n = PAD_FRAME;
          end else if (s_axis_tlast) begin
            state_n = PASS;
          end
        end
      end
      PAD_FRAME: begin
        if (out_free) begin
          emit = 1'b1;
          if (at_sof) begin
            emit_data = hold_data;
            if (hold_last) begin
              line_e  = 1'b1;
              state_n = PAD_LINE;
            end else begin
              state_n = PASS;
            end
          end
        end
      end
      default: state_n = SEEK;
    endcase
  end

  assign cnt_sum = {1'b0, err_cnt_o} + 17'(sof_e) + 17'(line_e);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= SEEK;
      x         <= '0;
      y         <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else begin
      state <= state_n;
      if (cap) begin
        hold_data <= s_axis_tdata;
        hold_last <= s_axis_tlast;
      end
      if (emit) begin
        if (at_eol) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (emit) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= emit_data;
      m_axis_tuser  <= user_v;
      m_axis_tlast  <= at_eol;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sof_err_o  <= 1'b0;
      line_err_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      sof_err_o  <= sof_e;
      line_err_o <= line_e;
      if (clr_err_i) begin
        err_cnt_o <= '0;
      end else if (cnt_sum[16]) begin
        err_cnt_o <= 16'hFFFF;
      end else begin
        err_cnt_o <= cnt_sum[15:0];
      end
    end
  end

endmodule
